// File: rtl/jt12_writer_pkg.sv
// Shared types for the JT12 register-bus writer: FSM states, queued command, address select bits.
package jt12_writer_pkg;

  typedef enum logic [2:0] {IDLE, POLL_A, WR_A, GAP_A, POLL_D, WR_D, GAP_D} state_t;

  typedef struct packed {
    logic       part;
    logic [7:0] regnum;
    logic [7:0] data;
  } cmd_t;

  localparam logic ADDR_SEL = 1'b0;
  localparam logic DATA_SEL = 1'b1;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/jt12_writer_fifo.sv
// Synchronous command FIFO; simultaneous push and pop keep the level unchanged.
module jt12_writer_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int WIDTH      = 17
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            din,
  output logic [WIDTH-1:0]            dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             do_push, do_pop;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/jt12_bus_writer.sv
// CPU-side writer for the JT12 register bus: queued (part, reg, data) writes become strobes.
// JT12_WRITER_POLL_EN enables status-busy polling; otherwise a fixed wait replaces the poll.
module jt12_bus_writer
  import jt12_writer_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int WR_CYCLES     = 2,
  parameter int GAP_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int TIMEOUT       = 1023,
  parameter int FIXED_WAIT    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_part,
  input  logic [7:0]                  cmd_reg,
  input  logic [7:0]                  cmd_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        idle,
  output logic                        timeout_err,
  input  logic                        err_clr,
  output logic [1:0]                  bus_addr,
  output logic [7:0]                  bus_din,
  output logic                        bus_cs_n,
  output logic                        bus_wr_n,
  input  logic [7:0]                  bus_dout
);
  localparam int CMAX = max_of(max_of(max_of(WR_CYCLES, GAP_CYCLES),
                                      max_of(SETTLE_CYCLES, TIMEOUT)), FIXED_WAIT);
  localparam int CW   = $clog2(CMAX + 1);

  cmd_t          in_cmd, head, hold;
  state_t        state;
  logic [CW-1:0] cnt;
  logic          full, empty, pop, poll_done, to_data;

  assign in_cmd    = '{part: cmd_part, regnum: cmd_reg, data: cmd_data};
  assign cmd_ready = !full;
  assign pop       = (state == IDLE) && !empty;
  assign idle      = empty && (state == IDLE);
  assign to_data   = (state == POLL_D);

  jt12_writer_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .WIDTH($bits(cmd_t))) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .pop   (pop),
    .din   (in_cmd),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

`ifdef JT12_WRITER_POLL_EN
  logic [CW-1:0] tcnt;
  logic          busy, settled, timeout_hit, unused_poll;
  assign busy        = bus_dout[7];
  assign settled     = (int'(cnt) + 1) >= SETTLE_CYCLES;
  assign timeout_hit = settled && busy && (tcnt == CW'(TIMEOUT - 1));
  assign poll_done   = settled && (!busy || timeout_hit);
  assign unused_poll = ^bus_dout[6:0];
`else
  logic unused_poll;
  assign poll_done   = (cnt == CW'(FIXED_WAIT - 1));
  assign timeout_err = 1'b0;
  assign unused_poll = ^{bus_dout, err_clr};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      hold     <= '0;
      bus_cs_n <= 1'b1;
      bus_wr_n <= 1'b1;
      bus_addr <= '0;
      bus_din  <= '0;
`ifdef JT12_WRITER_POLL_EN
      tcnt        <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
`ifdef JT12_WRITER_POLL_EN
      // a timeout in the same cycle overrides the clear below
      if (err_clr) timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: if (!empty) begin
          hold  <= head;
          cnt   <= '0;
          state <= POLL_A;
`ifdef JT12_WRITER_POLL_EN
          tcnt     <= '0;
          bus_cs_n <= 1'b0;
          bus_addr <= {head.part, ADDR_SEL};
`endif
        end
        POLL_A, POLL_D: begin
          if (poll_done) begin
            // cs_n high for one cycle with addr/din already set before the strobe
            bus_cs_n <= 1'b1;
            cnt      <= '0;
            bus_addr <= {hold.part, to_data ? DATA_SEL : ADDR_SEL};
            bus_din  <= to_data ? hold.data : hold.regnum;
            state    <= to_data ? WR_D : WR_A;
`ifdef JT12_WRITER_POLL_EN
            if (timeout_hit) timeout_err <= 1'b1;
`endif
          end
`ifdef JT12_WRITER_POLL_EN
          else if (!settled) cnt <= cnt + CW'(1);
          else if (tcnt != '1) tcnt <= tcnt + CW'(1);
`else
          else cnt <= cnt + CW'(1);
`endif
        end
        WR_A, WR_D: begin
          if (bus_cs_n) begin
            bus_cs_n <= 1'b0;
            bus_wr_n <= 1'b0;
            cnt      <= '0;
          end else if (cnt == CW'(WR_CYCLES - 1)) begin
            bus_cs_n <= 1'b1;
            bus_wr_n <= 1'b1;
            cnt      <= '0;
            state    <= (state == WR_A) ? GAP_A : GAP_D;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP_A, GAP_D: begin
          if (cnt == CW'(GAP_CYCLES - 1)) begin
            cnt <= '0;
            if (state == GAP_A) begin
              state <= POLL_D;
`ifdef JT12_WRITER_POLL_EN
              tcnt     <= '0;
              bus_cs_n <= 1'b0;
              bus_addr <= {hold.part, ADDR_SEL};
`endif
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt12_bus_writer.sv
// Scoreboard bench for jt12_bus_writer: each accepted command expects an address write then a data write.
module tb_jt12_bus_writer;
  localparam int DEPTH = 8, WR_CYCLES = 2, GAP_CYCLES = 2, SETTLE_CYCLES = 1;
  localparam int TIMEOUT = 1023, FIXED_WAIT = 32;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] din;
  } wr_t;

  logic       clk = 1'b0, rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_part = 1'b0, err_clr = 1'b0;
  logic [7:0] cmd_reg = '0, cmd_data = '0, bus_dout = '0;
  logic       cmd_ready, idle, timeout_err, bus_cs_n, bus_wr_n;
  logic [3:0] fifo_level;
  logic [1:0] bus_addr;
  logic [7:0] bus_din;

  always #5 clk = ~clk;

  jt12_bus_writer #(
    .FIFO_DEPTH(DEPTH), .WR_CYCLES(WR_CYCLES), .GAP_CYCLES(GAP_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES), .TIMEOUT(TIMEOUT), .FIXED_WAIT(FIXED_WAIT)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_part(cmd_part), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .fifo_level(fifo_level), .idle(idle), .timeout_err(timeout_err), .err_clr(err_clr),
    .bus_addr(bus_addr), .bus_din(bus_din), .bus_cs_n(bus_cs_n), .bus_wr_n(bus_wr_n),
    .bus_dout(bus_dout)
  );

  int  nvec = 0, nerr = 0;
  wr_t exp_q[$];
  bit  exp_err = 1'b0, full_seen = 1'b0, stuck = 1'b0;
  int  busy_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Chip model: after each write strobe the chip reports busy for busy_len cycles.
  int busy_cnt = 0;
  bit prev_wr_low = 1'b0;
  always @(posedge clk) begin
    #1;
    if (prev_wr_low && bus_wr_n) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    bus_dout    = {(stuck || busy_cnt > 0), 7'h5A};
    prev_wr_low = !bus_wr_n;
  end

  // Monitor: checks strobe shape and pops the scoreboard on every write strobe.
  logic       p_cs, p_wr;
  logic [1:0] p_addr, w_addr;
  logic [7:0] p_din, w_din;
  int         low_len, high_len, rd_len;
  bit         rd_busy_last, rd_seen, after_wr;
  wr_t        mon_e;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      p_cs = 1'b1; p_wr = 1'b1; p_addr = '0; p_din = '0; w_addr = '0; w_din = '0;
      low_len = 0; high_len = 0; rd_len = 0;
      rd_busy_last = 1'b0; rd_seen = 1'b0; after_wr = 1'b0;
    end else begin
      chk("ready_vs_level", cmd_ready, fifo_level != 4'(DEPTH));
      chk("level_bound", fifo_level <= 4'(DEPTH), 1);
      if (!cmd_ready) full_seen = 1'b1;
      if (!bus_cs_n && p_cs && after_wr) begin
        chk("gap_after_strobe", high_len >= GAP_CYCLES, 1);
        after_wr = 1'b0;
      end
      if (!bus_cs_n && bus_wr_n) begin
`ifdef JT12_WRITER_POLL_EN
        if (p_cs) begin
          rd_len = 0;
          if (exp_q.size() > 0) chk("status_read_addr", bus_addr, {exp_q[0].addr[1], 1'b0});
        end
        rd_len++;
        rd_busy_last = bus_dout[7];
        rd_seen = 1'b1;
`else
        chk("no_status_read", 1, 0);
`endif
      end
      if (!bus_wr_n && p_wr) begin
        chk("cs_wr_fall_together", {p_cs, bus_cs_n}, 2'b10);
        chk("addr_din_setup", {p_addr, p_din}, {bus_addr, bus_din});
        if (exp_q.size() == 0) chk("unexpected_write", {bus_addr, bus_din}, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("write_addr", bus_addr, mon_e.addr);
          chk("write_din", bus_din, mon_e.din);
        end
`ifdef JT12_WRITER_POLL_EN
        chk("polled_before_write", rd_seen, 1);
        if (rd_busy_last) begin
          chk("timeout_read_len", rd_len, SETTLE_CYCLES - 1 + TIMEOUT);
          chk("timeout_flag_set", timeout_err, 1);
        end else begin
          chk("timeout_flag", timeout_err, exp_err);
        end
`else
        if (bus_addr[0])
          chk("fixed_wait_len", (high_len >= GAP_CYCLES + FIXED_WAIT) &&
                                (high_len <= GAP_CYCLES + FIXED_WAIT + 1), 1);
        chk("timeout_tied_low", timeout_err, 0);
`endif
        rd_seen = 1'b0;
        low_len = 0;
        w_addr  = bus_addr;
        w_din   = bus_din;
      end
      if (!bus_wr_n) low_len++;
      if (bus_wr_n && !p_wr) begin
        chk("strobe_len", low_len, WR_CYCLES);
        chk("cs_wr_rise_together", bus_cs_n, 1);
        chk("addr_din_hold", {p_addr, p_din}, {w_addr, w_din});
        after_wr = 1'b1;
      end
      high_len = bus_cs_n ? (p_cs ? high_len + 1 : 1) : 0;
      p_cs = bus_cs_n; p_wr = bus_wr_n; p_addr = bus_addr; p_din = bus_din;
    end
  end

  // Offer one command; the scoreboard learns of it only when it is accepted.
  task automatic send(input logic p, input logic [7:0] r, input logic [7:0] d);
    int w = 0;
    cmd_part = p; cmd_reg = r; cmd_data = d; cmd_valid = 1'b1;
    while (!cmd_ready && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) chk("accept_timeout", 0, 1);
    else begin
      exp_q.push_back('{{p, 1'b0}, r});
      exp_q.push_back('{{p, 1'b1}, d});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    bit done = 1'b0;
    for (int n = 0; n < maxc && !done; n++) begin
      @(negedge clk);
      done = idle && (exp_q.size() == 0);
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_cs_n", bus_cs_n, 1);
    chk("rst_wr_n", bus_wr_n, 1);
    chk("rst_addr", bus_addr, 0);
    chk("rst_din", bus_din, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_timeout_err", timeout_err, 0);

    send(1'b0, 8'h28, 8'hF0);
    wait_idle(2000);
    send(1'b1, 8'hB4, 8'hC0);
    wait_idle(2000);

    busy_len = 50;
    send(1'b0, 8'hA4, 8'h22);
    wait_idle(2000);
    chk("stall_no_timeout", timeout_err, 0);
    busy_len = 0;

    // Busy stuck high
    stuck = 1'b1;
`ifdef JT12_WRITER_POLL_EN
    exp_err = 1'b1;
    send(1'b0, 8'h30, 8'h71);
    for (int n = 0; n < 3000 && !timeout_err; n++) @(negedge clk);
    chk("timeout_raised", timeout_err, 1);
    stuck = 1'b0;
    wait_idle(3000);
    chk("timeout_sticky", timeout_err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("timeout_cleared", timeout_err, 0);
    exp_err = 1'b0;
`else
    send(1'b0, 8'h30, 8'h71);
    wait_idle(3000);
    stuck = 1'b0;
    chk("timeout_tied_low_idle", timeout_err, 0);
`endif

    // Back-to-back burst fills the FIFO
    busy_len = 10;
    full_seen = 1'b0;
    for (int i = 0; i < 12; i++) send(1'($urandom_range(1)), 8'($urandom), 8'($urandom));
    chk("fifo_full_seen", full_seen, 1);
    wait_idle(20000);

    for (int i = 0; i < 20; i++) begin
      busy_len = $urandom_range(30);
      send(1'($urandom_range(1)), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(5)) @(negedge clk);
    end
    wait_idle(20000);

    // Reset during the data strobe of the first of several queued commands
    busy_len = 0;
    for (int i = 0; i < 4; i++) send(1'b1, 8'(8'h40 + i), 8'(8'h90 + i));
    begin
      bit hit = 1'b0;
      for (int n = 0; n < 3000 && !hit; n++) begin
        @(negedge clk);
        hit = !bus_wr_n && bus_addr[0];
      end
      chk("reach_wr_d", hit, 1);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_cs_n", bus_cs_n, 1);
    chk("midrst_wr_n", bus_wr_n, 1);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_idle", idle, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    send(1'b0, 8'hB0, 8'h3C);
    wait_idle(2000);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
